// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-access stage: memop codes, FSM states,
// wait budget default and big-endian byte-lane constants.
package cpu_mem_pkg;

  typedef enum logic [3:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LBU  = 4'd2,
    MEMOP_LH   = 4'd3,
    MEMOP_LHU  = 4'd4,
    MEMOP_LW   = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8,
    MEMOP_LL   = 4'd9,
    MEMOP_SC   = 4'd10
  } memop_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam int MAX_WAIT_DFLT = 15;

  // Lane 0 (lowest address) is bits 31:24.
  localparam logic [3:0] BE_BYTE_MSB = 4'b1000;
  localparam logic [3:0] BE_HALF_HI  = 4'b1100;
  localparam logic [3:0] BE_HALF_LO  = 4'b0011;
  localparam logic [3:0] BE_WORD     = 4'b1111;

  function automatic logic memop_is_load(input logic [3:0] op);
    return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW, MEMOP_LL};
  endfunction

  function automatic logic memop_is_store(input logic [3:0] op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SC};
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus handshake between the memory-access stage (master) and memory (slave).
interface mem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational big-endian lane mapping: byte enables, replicated store data,
// extended load result and misalignment flag for one memop/address.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] st,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Shift the addressed lane up to the top of the word.
  assign byte_sh = rdata << {addr, 3'b000};
  assign half_sh = rdata << {addr[1], 4'b0000};

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    ldata      = 32'h0;
    misaligned = 1'b0;
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
        be    = BE_BYTE_MSB >> addr;
        wdata = {4{st[7:0]}};
        ldata = (op == MEMOP_LB) ? {{24{byte_sh[31]}}, byte_sh[31:24]}
                                 : {24'h0, byte_sh[31:24]};
      end
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
        misaligned = addr[0];
        be         = addr[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata      = {2{st[15:0]}};
        ldata      = (op == MEMOP_LH) ? {{16{half_sh[31]}}, half_sh[31:16]}
                                      : {16'h0, half_sh[31:16]};
      end
      MEMOP_LW, MEMOP_SW, MEMOP_LL, MEMOP_SC: begin
        misaligned = |addr;
        be         = BE_WORD;
        wdata      = st;
        ldata      = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: stage register, bus access with wait/timeout,
// registered writeback and HI/LO forwarding. Optional LL/SC via MEM_LLSC_EN.
//
// state     | meaning
// ST_IDLE   | no request past its first cycle (first request cycle issues from M)
// ST_ACCESS | request outstanding for at least one cycle without ack
module mem_access
  import cpu_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DFLT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_whilo_i,
  input  logic [31:0] ex_hi_i,
  input  logic [31:0] ex_lo_i,
  input  logic [3:0]  ex_memop_i,
  input  logic [31:0] ex_maddr_i,
  input  logic [31:0] ex_mstore_i,
`ifdef MEM_LLSC_EN
  input  logic        llbit_clr_i,
`endif
  output logic        stall_o,
  mem_access_if.master bus,
  output logic        wb_wreg_o,
  output logic [4:0]  wb_wd_o,
  output logic [31:0] wb_wdata_o,
  output logic        wb_whilo_o,
  output logic [31:0] wb_hi_o,
  output logic [31:0] wb_lo_o,
  output logic        mem_whilo_o,
  output logic [31:0] mem_hi_o,
  output logic [31:0] mem_lo_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  logic        m_v, m_wreg, m_whilo;
  logic [4:0]  m_wd;
  logic [31:0] m_wdata, m_hi, m_lo, m_maddr, m_mstore;
  logic [3:0]  m_op;

  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt;
  logic        timeout, stall, retire, need_access, sc_fail, acked, timed_out;
  logic [3:0]  la_be;
  logic [31:0] la_wdata, la_ldata, wb_data_d;
  logic        la_misalign;

  mem_lane_align u_align (
    .op         (m_op),
    .addr       (m_maddr[1:0]),
    .st         (m_mstore),
    .rdata      (bus.rdata),
    .be         (la_be),
    .wdata      (la_wdata),
    .ldata      (la_ldata),
    .misaligned (la_misalign)
  );

`ifdef MEM_LLSC_EN
  logic llbit;
  assign sc_fail = (m_op == MEMOP_SC) && !llbit;

  always_ff @(posedge clk) begin
    if (rst)
      llbit <= 1'b0;
    else if (llbit_clr_i)
      llbit <= 1'b0;
    else if (retire && m_op == MEMOP_SC)
      llbit <= 1'b0;
    else if (retire && acked && m_op == MEMOP_LL)
      llbit <= 1'b1;
  end
`else
  assign sc_fail = 1'b0;
`endif

  assign need_access = m_v && (memop_is_load(m_op) || memop_is_store(m_op))
                       && !la_misalign && !sc_fail;
  assign acked       = need_access && bus.ack;
  assign timed_out   = timeout && !bus.ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v      <= 1'b0;
      m_wd     <= 5'd0;
      m_wreg   <= 1'b0;
      m_wdata  <= 32'h0;
      m_whilo  <= 1'b0;
      m_hi     <= 32'h0;
      m_lo     <= 32'h0;
      m_op     <= MEMOP_NONE;
      m_maddr  <= 32'h0;
      m_mstore <= 32'h0;
    end else if (!stall) begin
      m_v      <= ex_valid_i;
      m_wd     <= ex_wd_i;
      m_wreg   <= ex_wreg_i;
      m_wdata  <= ex_wdata_i;
      m_whilo  <= ex_whilo_i;
      m_hi     <= ex_hi_i;
      m_lo     <= ex_lo_i;
      m_op     <= ex_memop_i;
      m_maddr  <= ex_maddr_i;
      m_mstore <= ex_mstore_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= stall ? wait_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    timeout = need_access && (wait_cnt == 8'(MAX_WAIT));
    stall   = need_access && !bus.ack && !timeout;
    retire  = m_v && !stall;
    case (state_q)
      ST_IDLE:   if (stall)  state_d = ST_ACCESS;
      ST_ACCESS: if (!stall) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_data_d = m_wdata;
    if (memop_is_load(m_op))
      wb_data_d = la_ldata;
    else if (m_op == MEMOP_SC)
      wb_data_d = {31'h0, ~sc_fail};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wreg_o   <= 1'b0;
      wb_wd_o     <= 5'd0;
      wb_wdata_o  <= 32'h0;
      wb_whilo_o  <= 1'b0;
      wb_hi_o     <= 32'h0;
      wb_lo_o     <= 32'h0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      wb_wreg_o   <= retire && m_wreg && !la_misalign && !timed_out;
      wb_whilo_o  <= retire && m_whilo;
      align_err_o <= retire && la_misalign;
      bus_err_o   <= retire && timed_out;
      if (retire) begin
        wb_wd_o    <= m_wd;
        wb_wdata_o <= wb_data_d;
        wb_hi_o    <= m_hi;
        wb_lo_o    <= m_lo;
      end
    end
  end

  assign stall_o     = stall;
  assign bus.req     = need_access;
  assign bus.we      = need_access && memop_is_store(m_op);
  assign bus.addr    = need_access ? {m_maddr[31:2], 2'b00} : 32'h0;
  assign bus.be      = need_access ? la_be : 4'b0000;
  assign bus.wdata   = need_access ? la_wdata : 32'h0;

  assign mem_whilo_o = m_v && m_whilo;
  assign mem_hi_o    = m_v ? m_hi : 32'h0;
  assign mem_lo_o    = m_v ? m_lo : 32'h0;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access pipeline stage placed directly downstream of the execute stage. It latches the execute results (GPR write, HI/LO write, load/store request), performs the data-bus transaction with a wait-state handshake, aligns and extends load data, and presents a registered writeback bundle. It also drives the `mem_*` HI/LO forwarding inputs of execute and back-pressures it with `stall_o` while a bus access is pending.

## Interface
- MAX_WAIT, 15, bus wait cycles tolerated before an access is aborted (1..255)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  execute bundle valid this cycle
- ex_wd_i  in  5  destination GPR
- ex_wreg_i  in  1  GPR write enable
- ex_wdata_i  in  32  ALU result
- ex_whilo_i  in  1  HI/LO write enable
- ex_hi_i / ex_lo_i  in  32 each  HI/LO values
- ex_memop_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC
- ex_maddr_i  in  32  effective address
- ex_mstore_i  in  32  store data (rt)
- stall_o  out  1  execute must hold its bundle
- bus_req_o  out  1  access request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word address, bits [1:0] forced 0
- bus_be_o  out  4  byte enables, bit 3 = bits 31:24
- bus_wdata_o  out  32  lane-replicated store data
- bus_ack_i  in  1  access complete this cycle
- bus_rdata_i  in  32  load word, valid with ack
- wb_wreg_o, wb_wd_o[5], wb_wdata_o[32], wb_whilo_o, wb_hi_o[32], wb_lo_o[32]  out  registered writeback bundle
- mem_whilo_o, mem_hi_o[32], mem_lo_o[32]  out  HI/LO forwarding to execute
- align_err_o  out  1  one-cycle pulse, misaligned access dropped
- bus_err_o  out  1  one-cycle pulse, access timed out

## Operation
- Stage register M (m_v plus all ex_* fields) loads when !stall_o. If ex_valid_i=0, m_v is loaded with 0.
- FSM: IDLE (no pending memory op), ACCESS (m_v and memop≠NONE and aligned). ACCESS exits on ack or timeout.
- Alignment rule: for LH/LHU/SH, addr[0]≠0 is misaligned. For LW/SW/LL/SC, addr[1:0]≠0 is misaligned. A misaligned op issues no request. It retires next cycle with wb_wreg_o=0, and align_err_o pulses.
- Big-endian lanes. Bytes: be = 4'b1000 >> addr[1:0], wdata = {4{st[7:0]}}. Halves: be = addr[1] ? 0011 : 1100, wdata = {2{st[15:0]}}. Words: be = 1111.
- Loads take the addressed lane. LB/LH sign-extend; LBU/LHU zero-extend.
- Retire = m_v and (memop NONE, or misaligned, or ack, or timeout). On retire, wb_* takes M values (load data replaces wdata). Otherwise wb_wreg_o=0 and wb_whilo_o=0.
- Timeout: wait_cnt counts request cycles without ack. At MAX_WAIT the access is aborted: no GPR write, bus_err_o pulses, wait_cnt clears.
- mem_whilo_o/hi/lo = m_v ? M fields : 0.

## Timing
- stall_o = m_v & memop≠NONE & aligned & !bus_ack_i & !timeout (combinational).
- Non-memory op: captured at edge N, wb valid after edge N+1. Same latency with zero-wait ack (ack in first request cycle).
- Each wait cycle adds one cycle. bus_* outputs stay stable while stall_o=1.
- Reset: all outputs 0, m_v=0, FSM IDLE, wait_cnt=0, llbit=0. Reset during ACCESS drops the request on the next cycle and produces no writeback.
- If ack and timeout occur in the same cycle, ack wins.

## Configuration
- MEM_LLSC_EN defined: the llbit register and the llbit_clr_i input (1 bit, clears llbit on exception/eret) are included.
  - LL behaves as LW and sets llbit on retire.
  - SC with llbit=1 stores and writes 1 to wd. SC with llbit=0 issues no request and writes 0.
  - Any SC retire clears llbit.
  - llbit_clr_i has priority over an LL set in the same cycle.
- MEM_LLSC_EN undefined: there is no llbit and no llbit_clr_i port. LL behaves as LW. SC behaves as SW and writes 1 to wd.

## Structure
- Package cpu_mem_pkg holds: memop codes, FSM state enum, MAX_WAIT default, and the big-endian lane constants.
- Sub-module mem_lane_align (combinational) maps memop/addr/store/rdata to be, wdata, load result, and misaligned.

## Test plan
- ALU op wdata=0x1234, wd=3, memop NONE → wb_wreg_o=1, wb_wdata_o=0x1234 after two edges, stall_o never 1.
- LB addr 0x101, rdata 0x11A2_3344, ack after 2 waits → be=0100, stall_o 2 cycles, wb_wdata_o=0xFFFF_FFA2.
- SH addr 0x202, st 0xCAFE_BEEF, zero-wait ack → be=0011, wdata=0xBEEF_BEEF, we=1, wb_wreg_o=0.
- LW addr 0x302 → no bus_req_o, align_err_o one pulse, wb_wreg_o=0.
- LW never acked, MAX_WAIT=15 → stall_o high 15 cycles, bus_err_o pulse, no writeback, next bundle accepted.
- MEM_LLSC_EN: LL 0x40, then llbit_clr_i, then SC 0x40 → SC issues no request, wb_wdata_o=0.
